// File: rtl/sevenseg_scan_driver.sv
// Four-digit common-anode multiplexed 7-segment driver. It adds guard blanking,
// frame-synchronous input shadowing, leading-zero blanking, a fixed decimal point and flashing.
module sevenseg_scan_driver #(
    parameter int unsigned DIGIT_TICKS  = 100000,
    parameter int unsigned GUARD        = 16,
    parameter int unsigned DP_POS       = 2,
    parameter int unsigned BLINK_FRAMES = 128
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic       blank_en,
    input  logic       flash,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_sync
);

    localparam int unsigned PW = (DIGIT_TICKS > 1)  ? $clog2(DIGIT_TICKS)  : 1;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]   pre;
    logic [1:0]      idx;
    logic [3:0][3:0] shadow;
    logic [BW-1:0]   blink_cnt;
    logic            phase_on;

    logic       load;
    logic       guard;
    logic       dark;
    logic       blanked;
    logic [3:0] lz;
    logic [3:0] an_nx;
    logic [6:0] seg_nx;
    logic       dp_nx;

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0:    enc = 7'b1000000;
            4'd1:    enc = 7'b1111001;
            4'd2:    enc = 7'b0100100;
            4'd3:    enc = 7'b0110000;
            4'd4:    enc = 7'b0011001;
            4'd5:    enc = 7'b0010010;
            4'd6:    enc = 7'b0000010;
            4'd7:    enc = 7'b1111000;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0010000;
            default: enc = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        load  = (pre == '0) && (idx == 2'd0);
        guard = pre < PW'(GUARD);
        // flash only darkens while it is still asserted, so dropping it takes effect at once
        dark  = flash && !phase_on;

        lz[3] = (shadow[3] == 4'd0);
        lz[2] = lz[3] && (shadow[2] == 4'd0);
        lz[1] = lz[2] && (shadow[1] == 4'd0);
        lz[0] = lz[1] && (shadow[0] == 4'd0);
        blanked = blank_en && (32'(idx) > DP_POS) && lz[idx];

        an_nx  = '1;
        seg_nx = '1;
        dp_nx  = 1'b1;
        if (!guard) begin
            if (!blanked) begin
                an_nx[idx] = 1'b0;
                seg_nx     = enc(shadow[idx]);
            end
            dp_nx = !(32'(idx) == DP_POS);
        end
        if (dark) begin
            an_nx = '1;
            dp_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre        <= '0;
            idx        <= 2'd0;
            shadow     <= '0;
            blink_cnt  <= '0;
            phase_on   <= 1'b1;
            an         <= '1;
            seg        <= '1;
            dp         <= 1'b1;
            frame_sync <= 1'b0;
        end else begin
            frame_sync <= load;
            if (pre == PW'(DIGIT_TICKS - 1)) begin
                pre <= '0;
                idx <= idx + 2'd1;
            end else begin
                pre <= pre + PW'(1);
            end

            if (load) begin
                shadow <= {d3, d2, d1, d0};
            end

            if (!flash) begin
                blink_cnt <= '0;
                phase_on  <= 1'b1;
            end else if (load) begin
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    phase_on  <= !phase_on;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end

            an  <= an_nx;
            seg <= seg_nx;
            dp  <= dp_nx;
        end
    end

endmodule
